parking_gate_scheduler: RTL
===========================

# parking_gate_scheduler

Sequences the single shared barrier gate of the parking lot between the entry and exit lanes, using the 1 Hz and 2 Hz square waves produced by the frequency divider as its time base. It arbitrates between the two lanes, opens the gate for the winner, times out abandoned requests, tracks lot occupancy against capacity, and drives the gate-warning lamp. It sits between the lane sensors and the gate motor driver, downstream of the divider.

## Interface
- CAPACITY, 8: number of parking spots; must be ≥1.
- OCC_W, 4: occupancy width; must satisfy 2^OCC_W > CAPACITY.
- HOLD_SECS, 3: seconds the gate stays open after a car clears the beam.
- TIMEOUT_SECS, 10: seconds allowed for a car to break the beam after opening.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  1 Hz square wave from the divider; asynchronous to this block's logic.
- clk_2Hz  in  1  2 Hz square wave from the divider; asynchronous to this block's logic.
- entry_req  in  1  level; car waiting at the entry lane. Already debounced and synchronous to clk.
- exit_req  in  1  level; car waiting at the exit lane. Already debounced and synchronous to clk.
- car_pass  in  1  level; high while the gate beam is broken. Already debounced and synchronous to clk.
- gate_open  out  1  gate motor command; 1 = open.
- gate_dir  out  1  lane currently served; 0 = entry, 1 = exit.
- lamp  out  1  warning lamp.
- full  out  1  high when occupancy == CAPACITY.
- occupancy  out  OCC_W  number of cars in the lot.
- timeout_err  out  1  one-cycle pulse when an open gate times out.

## Operation
- Tick generation:
  - clk_1Hz and clk_2Hz each pass through a 2-flop synchronizer and a rising-edge detector.
  - This produces tick1 and tick2, each a one-cycle pulse.
- The FSM has four states: IDLE, OPEN, PASS, HOLD. A seconds counter (sec_cnt) is cleared on every state entry and increments on tick1.
- IDLE:
  - gate_open=0 and lamp=0.
  - The entry lane is eligible when entry_req & ~full.
  - The exit lane is eligible when exit_req & (occupancy≠0).
  - With one eligible lane, that lane is granted. With both eligible, the lane opposite last_dir is granted (round-robin).
  - On a grant: set gate_dir, set last_dir, move to OPEN.
- OPEN:
  - gate_open=1.
  - car_pass=1 → PASS.
  - Otherwise, when sec_cnt reaches TIMEOUT_SECS → IDLE with a timeout_err pulse. Occupancy is unchanged.
- PASS:
  - gate_open=1.
  - On car_pass falling: occupancy is incremented if gate_dir=0 and decremented if gate_dir=1, then the FSM moves to HOLD.
  - Occupancy saturates at CAPACITY and at 0; it never wraps.
- HOLD:
  - gate_open=1.
  - car_pass=1 → PASS. A tailgater is counted on its own falling edge.
  - When sec_cnt reaches HOLD_SECS → IDLE.
- Lamp: set to 1 on entry to OPEN, toggles on every tick2 while gate_open=1, and is forced to 0 in IDLE.
- full is combinational from occupancy.
- Simultaneous events: a car_pass transition in the same cycle as a tick1-driven expiry takes priority, so the expiry is ignored.
- Requests that drop while the gate is already open have no effect. The grant completes through the normal flow.

## Timing
- Reset values (asynchronous, active-low): state=IDLE, gate_open=0, gate_dir=0, lamp=0, occupancy=0, full=0, timeout_err=0, last_dir=1 (so entry wins the first tie), sec_cnt=0, all synchronizer flops 0.
- Reset asserted mid-operation returns everything to the reset values, including occupancy.
- Tick latency: tick pulses one cycle after the 2nd synchronizer flop captures the rising edge, i.e. 2–3 clk cycles after the input edge. Pulse width is exactly one cycle.
- Grant latency: gate_open rises on the clk edge after an eligible request is seen in IDLE (1 cycle).
- PASS→HOLD transition and the occupancy update occur on the same edge, the first edge at which car_pass=0 is sampled.
- Expiry accuracy: the first tick after state entry may arrive anywhere in the first second. Expiry therefore occurs between N−1 and N seconds after entry, for N = TIMEOUT_SECS or HOLD_SECS.
- The IDLE→OPEN transition may occur on the cycle immediately after HOLD→IDLE. There is no dead cycle requirement.

## Configuration
- EXIT_PRIORITY_EN:
  - Defined: when both lanes are eligible, the exit lane always wins. last_dir is not used for arbitration.
  - Undefined: round-robin arbitration as described in Operation.

## Test plan
- Reset mid-PASS with occupancy=5 → next cycle: occupancy=0, gate_open=0, lamp=0, state IDLE.
- entry_req=1, car_pass pulse during OPEN → occupancy 0→1 on car_pass fall; gate_open drops 3 s (HOLD_SECS) later; lamp toggles at 2 Hz while the gate is open.
- entry_req=exit_req=1 with occupancy=2, repeated passes → grants alternate entry, exit, entry. With EXIT_PRIORITY_EN: exit, exit, then entry once occupancy reaches 0.
- exit_req=1, no car_pass → timeout_err pulses once 9–10 s after gate_open rises; occupancy unchanged.
- Fill to CAPACITY=8 → full=1; entry_req alone is not granted; occupancy does not exceed 8. exit_req=1 with occupancy=0 is not granted.
- Tailgate: car_pass rises again during HOLD with gate_dir=0 → two increments total; gate stays open throughout.

Source files
------------

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler
//   Sequences the single shared barrier gate between the entry and exit lanes.
//   Arbitrates the two lanes, opens the gate for the winner, times out a car
//   that never breaks the beam, tracks occupancy against CAPACITY and drives
//   the gate-warning lamp. The time base is the 1 Hz / 2 Hz divider outputs,
//   which are resynchronised here and turned into one-cycle ticks.
//
//   Parameters
//     CAPACITY      number of parking spots (>= 1)
//     OCC_W         occupancy width, 2**OCC_W > CAPACITY
//     HOLD_SECS     seconds the gate stays open after the beam clears (>= 1)
//     TIMEOUT_SECS  seconds allowed for a car to break the beam (>= 1)
//
//   Ports
//     clk          system clock
//     reset        asynchronous, active-low reset
//     clk_1Hz      1 Hz square wave, asynchronous to clk
//     clk_2Hz      2 Hz square wave, asynchronous to clk
//     entry_req    car waiting at the entry lane (level, synchronous)
//     exit_req     car waiting at the exit lane (level, synchronous)
//     car_pass     high while the gate beam is broken (level, synchronous)
//     gate_open    gate motor command, 1 = open
//     gate_dir     lane being served, 0 = entry, 1 = exit
//     lamp         warning lamp
//     full         occupancy == CAPACITY
//     occupancy    cars currently in the lot
//     timeout_err  one-cycle pulse when an open gate times out
//
//   Build option
//     EXIT_PRIORITY_EN  when defined, the exit lane always wins a tie;
//                       otherwise ties are resolved round-robin.

module parking_gate_scheduler #(
  parameter int CAPACITY     = 8,
  parameter int OCC_W        = 4,
  parameter int HOLD_SECS    = 3,
  parameter int TIMEOUT_SECS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_1Hz,
  input  logic             clk_2Hz,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_pass,
  output logic             gate_open,
  output logic             gate_dir,
  output logic             lamp,
  output logic             full,
  output logic [OCC_W-1:0] occupancy,
  output logic             timeout_err
);

  localparam int SEC_MAX = (HOLD_SECS > TIMEOUT_SECS) ? HOLD_SECS : TIMEOUT_SECS;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  // Expiry fires on the tick that would bring sec_cnt up to N, so the
  // comparison is against N-1 and the transition lands on that tick's edge.
  localparam logic [SEC_W-1:0] HOLD_LAST    = SEC_W'(HOLD_SECS - 1);
  localparam logic [SEC_W-1:0] TIMEOUT_LAST = SEC_W'(TIMEOUT_SECS - 1);
  localparam logic [OCC_W-1:0] CAP          = OCC_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    PASS = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state;
  logic [SEC_W-1:0] sec_cnt;
  logic             last_dir;

  // [0] and [1] form the synchronizer; [2] holds the previous synchronized
  // value for the rising-edge detector.
  logic [2:0]       sync_1hz;
  logic [2:0]       sync_2hz;
  logic             tick1;
  logic             tick2;

  logic             entry_ok;
  logic             exit_ok;
  logic             grant_exit;

  // Occupancy moves by one car and saturates at both ends instead of wrapping.
  function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                input logic             dir);
    if (!dir)
      return (occ >= CAP) ? CAP : occ + OCC_W'(1);
    else
      return (occ == '0) ? '0 : occ - OCC_W'(1);
  endfunction

  // Tick generation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1hz <= '0;
      sync_2hz <= '0;
    end else begin
      sync_1hz <= {sync_1hz[1:0], clk_1Hz};
      sync_2hz <= {sync_2hz[1:0], clk_2Hz};
    end
  end

  assign tick1 = sync_1hz[1] & ~sync_1hz[2];
  assign tick2 = sync_2hz[1] & ~sync_2hz[2];

  // Lane arbitration
  assign full     = (occupancy == CAP);
  assign entry_ok = entry_req & ~full;
  assign exit_ok  = exit_req & (occupancy != '0);

`ifdef EXIT_PRIORITY_EN
  assign grant_exit = exit_ok;
`else
  // On a tie, serve the lane opposite to the one served last.
  assign grant_exit = exit_ok & (~entry_ok | ~last_dir);
`endif

  // Gate sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      gate_open   <= 1'b0;
      gate_dir    <= 1'b0;
      lamp        <= 1'b0;
      occupancy   <= '0;
      timeout_err <= 1'b0;
      last_dir    <= 1'b1;
      sec_cnt     <= '0;
    end else begin
      timeout_err <= 1'b0;

      // The lamp blinks at 2 Hz whenever the gate is open; the branches below
      // override this when the gate closes.
      if (state != IDLE && tick2)
        lamp <= ~lamp;

      case (state)
        IDLE: begin
          gate_open <= 1'b0;
          lamp      <= 1'b0;
          sec_cnt   <= '0;
          if (entry_ok | exit_ok) begin
            state     <= OPEN;
            gate_dir  <= grant_exit;
            last_dir  <= grant_exit;
            gate_open <= 1'b1;
            lamp      <= 1'b1;
          end
        end

        OPEN: begin
          // A beam break wins over an expiry landing on the same edge.
          if (car_pass) begin
            state   <= PASS;
            sec_cnt <= '0;
          end else if (tick1 && sec_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            lamp        <= 1'b0;
            timeout_err <= 1'b1;
            sec_cnt     <= '0;
          end else if (tick1) begin
            sec_cnt <= sec_cnt + SEC_W'(1);
          end
        end

        PASS: begin
          // PASS is only entered with car_pass high, so the first low sample
          // is the falling edge that counts the car.
          if (!car_pass) begin
            state     <= HOLD;
            occupancy <= occ_step(occupancy, gate_dir);
            sec_cnt   <= '0;
          end
        end

        HOLD: begin
          // A tailgater re-enters PASS and restarts the hold time afterwards.
          if (car_pass) begin
            state   <= PASS;
            sec_cnt <= '0;
          end else if (tick1 && sec_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gate_open <= 1'b0;
            lamp      <= 1'b0;
            sec_cnt   <= '0;
          end else if (tick1) begin
            sec_cnt <= sec_cnt + SEC_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
          lamp      <= 1'b0;
          sec_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
